// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access sequencer: FSM states, the latched
// memory op, and byte-lane geometry of the 32-bit memory word.
package dmem_access_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP,
      ST_WB,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic        load;
      logic        store;
      logic        byte_op;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_op_s;

   localparam int LANE_W     = 8;
   localparam int NUM_LANES  = 4;
   localparam int LANE_SEL_W = 2;

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane helper: zero-extended extract of one lane, and a merge that
// replaces only the selected lane (read-modify-write for byte stores).
module dmem_byte_lane
   import dmem_access_ctrl_pkg::*;
(
   input  logic [31:0]           word_i,
   input  logic [LANE_SEL_W-1:0] sel_i,
   input  logic [LANE_W-1:0]     byte_i,
   output logic [31:0]           ext_o,
   output logic [31:0]           merge_o
);

   logic [LANE_W-1:0] lanes [NUM_LANES];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign lanes[gi] = word_i[gi*LANE_W +: LANE_W];
         assign merge_o[gi*LANE_W +: LANE_W] =
            (sel_i == LANE_SEL_W'(gi)) ? byte_i : lanes[gi];
      end
   endgenerate

   assign ext_o = {{(32-LANE_W){1'b0}}, lanes[sel_i]};

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle sequencer between the memory stage and a word-only data memory:
// word reads/writes over valid/yumi, RMW for SB, zero-extended LBU.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid_i,
   input  logic              is_load_i,
   input  logic              is_store_i,
   input  logic              is_byte_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [31:0]       load_data_o,
   output logic              misalign_o,
   output logic              mem_v_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_yumi_i,
   input  logic              mem_rv_i,
   input  logic [31:0]       mem_rdata_i
);

   state_e      state_q, state_d;
   mem_op_s     op_q, op_d;
   logic [31:0] load_data_q, load_data_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        done_q, done_d;
   logic        misalign_q, misalign_d;
   logic        mem_v_q, mem_v_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] lane_ext;
   logic [31:0] lane_merge;
   logic        unused_op_bits;

   dmem_byte_lane u_byte_lane (
      .word_i  (mem_rdata_i),
      .sel_i   (op_q.addr[LANE_SEL_W-1:0]),
      .byte_i  (op_q.wdata[LANE_W-1:0]),
      .ext_o   (lane_ext),
      .merge_o (lane_merge)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      load_data_d = load_data_q;
      mem_wdata_d = mem_wdata_q;
      misalign_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               op_d.load    = is_load_i;
               op_d.store   = is_store_i & ~is_load_i;
               op_d.byte_op = is_byte_i;
               op_d.addr    = addr_i;
               op_d.wdata   = wdata_i;
               mem_wdata_d  = wdata_i;
               if (!is_load_i && !is_store_i) begin
                  state_d = ST_DONE;
               end else if (!is_byte_i && addr_i[1:0] != 2'b00) begin
                  state_d    = ST_DONE;
                  misalign_d = 1'b1;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_yumi_i) begin
               state_d = (op_q.store && !op_q.byte_op) ? ST_DONE : ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_rv_i) begin
               if (op_q.load) begin
                  load_data_d = op_q.byte_op ? lane_ext : mem_rdata_i;
                  state_d     = ST_DONE;
               end else begin
                  mem_wdata_d = lane_merge;
                  state_d     = ST_WB;
               end
            end
         end
         ST_WB: begin
            if (mem_yumi_i) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Handshake outputs follow the next state so they are registered.
      done_d   = (state_d == ST_DONE);
      mem_v_d  = (state_d == ST_REQ) || (state_d == ST_WB);
      mem_we_d = (state_d == ST_WB) ||
                 ((state_d == ST_REQ) && op_d.store && !op_d.byte_op);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         load_data_q <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         misalign_q  <= 1'b0;
         mem_v_q     <= 1'b0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         load_data_q <= load_data_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         misalign_q  <= misalign_d;
         mem_v_q     <= mem_v_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign unused_op_bits = ^{op_q.addr[31:ADDR_W+2], op_q.wdata[31:LANE_W]};

   assign stall_o     = req_valid_i & ~done_q;
   assign done_o      = done_q;
   assign misalign_o  = misalign_q;
   assign load_data_o = load_data_q;
   assign mem_v_o     = mem_v_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = op_q.addr[ADDR_W+1:2];
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle sequencer between the core's memory stage and a word-wide data memory that has no byte write enables.
- Consumes the decoded memory-op flags: load, store, byte.
- Issues word reads and writes over a valid/yumi handshake, performs read-modify-write for SB, and extracts and zero-extends bytes for LBU.
- Produces the stall, load-writeback data and done signals used by the pipeline.

Parameters:
- ADDR_W, 10, word-address width of the data memory. Byte address bits [ADDR_W+1:2] form mem_addr_o.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  memory op present in the memory stage; held until done_o.
- is_load_i  in  1  decoded load (LW/LBU).
- is_store_i  in  1  decoded store (SW/SB).
- is_byte_i  in  1  byte-sized op (LBU/SB).
- addr_i  in  32  byte address.
- wdata_i  in  32  store data; SB uses bits [7:0].
- stall_o  out  1  freeze upstream stages.
- done_o  out  1  one-cycle completion pulse.
- load_data_o  out  32  load result, valid when done_o is high for a load.
- misalign_o  out  1  pulses with done_o when a word op is misaligned.
- mem_v_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_W  word address.
- mem_wdata_o  out  32  write data.
- mem_yumi_i  in  1  memory accepts the request this cycle.
- mem_rv_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.

Behaviour:
- States: IDLE, REQ, RESP, WB, DONE.
- Reset (async, any state): state=IDLE; mem_v_o=0, mem_we_o=0, done_o=0, misalign_o=0; load_data_o=0; latched op cleared. Outputs go low immediately, mid-transaction included. Memory-side cleanup is the memory's responsibility.
- IDLE:
  - req_valid_i=1 latches op, addr and wdata.
  - If the op is a word op with addr_i[1:0]!=0, go to DONE with misalign_o=1; no memory access.
  - Otherwise go to REQ.
  - If is_load_i and is_store_i are both 1, load wins.
  - If req_valid_i=1 with neither flag set, go to DONE with no access.
- REQ:
  - mem_v_o=1, mem_addr_o=latched addr[ADDR_W+1:2].
  - mem_we_o=1 only for SW; SB and all loads read first.
  - Hold every request field stable until mem_yumi_i.
  - On yumi: SW goes to DONE; all others go to RESP.
- RESP:
  - Wait for mem_rv_i. rv is only valid at least 1 cycle after yumi; rv in any other state is ignored.
  - LW: load_data_o=mem_rdata_i.
  - LBU: load_data_o={24'b0, lane}. Lane select is little-endian on addr[1:0]: 0 selects [7:0], 3 selects [31:24].
  - SB: register the merged word, with only the addressed lane replaced by wdata[7:0]; go to WB.
  - Loads go to DONE.
- WB: mem_v_o=1, mem_we_o=1, mem_wdata_o=merged word; on yumi go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. The next request is accepted no earlier than the following cycle.
- load_data_o is registered and holds until the next load completes.
- stall_o = req_valid_i & ~done_o (combinational).
- Unbounded memory wait states are tolerated; there is no timeout.
- Latency from accept to done_o, zero-wait memory (yumi with v, rv the next cycle):
  - SW: 2 cycles.
  - LW/LBU: 3 cycles.
  - SB: 4 cycles.
  - Misaligned or no-op: 1 cycle.
- mem_yumi_i while mem_v_o=0 is ignored.

Decomposition:
- Shared package:
  - state enum.
  - mem_op_s struct {load, store, byte, addr[31:0], wdata[31:0]}.
  - byte-lane constants.
- Sub-module dmem_byte_lane (combinational): lane extract with zero-extend, and lane merge for RMW. Reused by any future cache path.

Test Plan:
- LW addr=0x10, memory returns 0xDEADBEEF with zero-wait → mem_addr_o=4 read, done_o 3 cycles after accept, load_data_o=0xDEADBEEF, stall_o high until done.
- LBU addr=0x13, word 0xAABBCCDD → load_data_o=0x000000AA; addr=0x10 gives 0x000000DD.
- SB addr=0x21, wdata=0x12345677, memory word 0x11223344 → read at word 8, then write 0x11227744 at word 8; done_o 4 cycles after accept.
- SW addr=0x06 → misalign_o=1 and done_o next cycle; mem_v_o stays 0.
- SW with yumi withheld 5 cycles → mem_v_o, we, addr and wdata stable throughout; done_o the cycle after yumi; stall_o high throughout.
- reset_n low in RESP of an LBU → mem_v_o and done_o go 0 immediately, state IDLE; after release a fresh LW completes normally.
